// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: shared constants for the in-place 8-point radix-2 FFT sequencer.
//   - FSM state encoding (3-bit, plain constants for legacy tools)
//   - transform size, stage count and data-memory address width
//   - complex word layout helpers ({re[31:16], im[15:0]})
package fft_seq_pkg;

  localparam int unsigned FFT_N      = 8;
  localparam int unsigned FFT_STAGES = 3;
  localparam int unsigned DM_AW      = 5;
  localparam int unsigned DM_DW      = 32;

  // Butterfly index within a stage (FFT_N/2 butterflies) and stage index widths.
  localparam int unsigned BF_W = 2;
  localparam int unsigned ST_W = 2;
  localparam int unsigned TW_W = 2;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRdA  = 3'd1;
  localparam logic [2:0] StRdB  = 3'd2;
  localparam logic [2:0] StCalc = 3'd3;
  localparam logic [2:0] StWrA  = 3'd4;
  localparam logic [2:0] StWrB  = 3'd5;
  localparam logic [2:0] StNext = 3'd6;
  localparam logic [2:0] StFin  = 3'd7;

  localparam logic [BF_W-1:0] LastBfly  = BF_W'(FFT_N / 2 - 1);
  localparam logic [ST_W-1:0] LastStage = ST_W'(FFT_STAGES - 1);

endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: combinational operand-address and twiddle generator for one
// butterfly of an in-place decimation-in-time 8-point FFT.
//   base   in  DM_AW  word address of x[0] (bit-reversed input order)
//   stage  in  ST_W   current stage s (0..2)
//   bfly   in  BF_W   butterfly k within the stage (0..3)
//   addr_a out DM_AW  (base + ia) mod 32
//   addr_b out DM_AW  (base + ib) mod 32, ib = ia + 2^s
//   tw     out TW_W   twiddle exponent of W8
module fft_addr_gen
  import fft_seq_pkg::*;
(
  input  logic [DM_AW-1:0] base,
  input  logic [ST_W-1:0]  stage,
  input  logic [BF_W-1:0]  bfly,
  output logic [DM_AW-1:0] addr_a,
  output logic [DM_AW-1:0] addr_b,
  output logic [TW_W-1:0]  tw
);

  logic [2:0]      half;
  logic [BF_W-1:0] pos;
  logic [BF_W-1:0] grp;
  logic [2:0]      ia;
  logic [2:0]      ib;

  always_comb begin
    half = 3'b001 << stage;
    pos  = bfly & BF_W'(half - 3'd1);
    grp  = bfly >> stage;
    // grp * 2 * half is a shift by s+1; stage never exceeds 2 so s+1 fits in 2 bits.
    ia   = 3'({3'b000, grp} << (stage + 2'd1)) + {1'b0, pos};
    ib   = ia + half;
    tw   = TW_W'(pos << (2'd2 - stage));
    // Window may straddle the top of memory; 5-bit addition wraps silently.
    addr_a = base + {2'b00, ia};
    addr_b = base + {2'b00, ib};
  end

endmodule

// File: rtl/fft_seq.sv
// fft_seq: multi-cycle sequencer that runs an in-place 8-point FFT on data
// memory by borrowing the pipeline's data-memory port and an external
// butterfly unit. Twelve butterflies (3 stages x 4) each take
// read A, read B, compute, write A, write B, advance.
//   clk, rst           clock, asynchronous active-low reset
//   start, base_addr   one-cycle request and address of x[0]
//   busy, done, stall  status to the pipeline (stall = busy | start)
//   dm_sel             data-memory port ownership (1 = fft_seq)
//   mem_rena/wena/addr/wdata, mem_rdata   data-memory port
//   bf_a, bf_b, bf_tw, bf_valid / bf_ready, bf_ya, bf_yb   butterfly handshake
module fft_seq
  import fft_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DM_AW-1:0] base_addr,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             dm_sel,
  output logic             mem_rena,
  output logic             mem_wena,
  output logic [DM_AW-1:0] mem_addr,
  output logic [DM_DW-1:0] mem_wdata,
  input  logic [DM_DW-1:0] mem_rdata,
  output logic [DM_DW-1:0] bf_a,
  output logic [DM_DW-1:0] bf_b,
  output logic [TW_W-1:0]  bf_tw,
  output logic             bf_valid,
  input  logic             bf_ready,
  input  logic [DM_DW-1:0] bf_ya,
  input  logic [DM_DW-1:0] bf_yb
);

  logic [2:0]       state_q, state_d;
  logic [DM_AW-1:0] base_q, base_d;
  logic [ST_W-1:0]  stage_q, stage_d;
  logic [BF_W-1:0]  bfly_q, bfly_d;
  logic [DM_DW-1:0] op_a_q, op_a_d;
  logic [DM_DW-1:0] op_b_q, op_b_d;
  logic [DM_DW-1:0] res_a_q, res_a_d;
  logic [DM_DW-1:0] res_b_q, res_b_d;

  logic [DM_AW-1:0] addr_a;
  logic [DM_AW-1:0] addr_b;
  logic [TW_W-1:0]  tw;

  fft_addr_gen u_addr_gen (
    .base   (base_q),
    .stage  (stage_q),
    .bfly   (bfly_q),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .tw     (tw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      stage_q <= '0;
      bfly_q  <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_a_q <= '0;
      res_b_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_a_q <= res_a_d;
      res_b_q <= res_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_a_d = res_a_q;
    res_b_d = res_b_q;
    case (state_q)
      StIdle: begin
        // Only IDLE looks at start, so a request while running is dropped.
        if (start) begin
          base_d  = base_addr;
          stage_d = '0;
          bfly_d  = '0;
          state_d = StRdA;
        end
      end
      StRdA: begin
        op_a_d  = mem_rdata;
        state_d = StRdB;
      end
      StRdB: begin
        op_b_d  = mem_rdata;
        state_d = StCalc;
      end
      StCalc: begin
        if (bf_ready) begin
          res_a_d = bf_ya;
          res_b_d = bf_yb;
          state_d = StWrA;
        end
      end
      StWrA: state_d = StWrB;
      StWrB: state_d = StNext;
      StNext: begin
        if (bfly_q != LastBfly) begin
          bfly_d  = bfly_q + 1'b1;
          state_d = StRdA;
        end else if (stage_q != LastStage) begin
          stage_d = stage_q + 1'b1;
          bfly_d  = '0;
          state_d = StRdA;
        end else begin
          state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // busy already drops in FIN so the pipeline resumes in step with done.
  always_comb begin
    busy     = (state_q != StIdle) && (state_q != StFin);
    done     = (state_q == StFin);
    stall    = busy | start;
    dm_sel   = (state_q != StIdle);
    mem_rena = (state_q == StRdA) || (state_q == StRdB);
    mem_wena = (state_q == StWrA) || (state_q == StWrB);
    bf_valid = (state_q == StCalc);
    bf_a     = op_a_q;
    bf_b     = op_b_q;
    bf_tw    = tw;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      StRdA:   mem_addr = addr_a;
      StRdB:   mem_addr = addr_b;
      StWrA: begin
        mem_addr  = addr_a;
        mem_wdata = res_a_q;
      end
      StWrB: begin
        mem_addr  = addr_b;
        mem_wdata = res_b_q;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fft_seq.sv
// tb_fft_seq: self-checking bench for fft_seq. Models the data memory and a
// Q15 butterfly unit with programmable ready delay; a reference FFT schedule
// fills scoreboard queues with expected reads, operands and writes.
module tb_fft_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  base_addr = '0;
  logic        busy, done, stall, dm_sel, mem_rena, mem_wena, bf_valid, bf_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, bf_a, bf_b, bf_ya, bf_yb;
  logic [1:0]  bf_tw;

  fft_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .dm_sel    (dm_sel),
    .mem_rena  (mem_rena),
    .mem_wena  (mem_wena),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .bf_a      (bf_a),
    .bf_b      (bf_b),
    .bf_tw     (bf_tw),
    .bf_valid  (bf_valid),
    .bf_ready  (bf_ready),
    .bf_ya     (bf_ya),
    .bf_yb     (bf_yb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Unscaled radix-2 butterfly with Q15 twiddles W8^k = exp(-j*2*pi*k/8).
  function automatic logic [31:0] bfly_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] tw, input bit lower);
    longint wr, wi, ar, ai, br, bi, pr, pi, yr, yi;
    case (tw)
      2'd0:    begin wr = 32767;  wi = 0;      end
      2'd1:    begin wr = 23170;  wi = -23170; end
      2'd2:    begin wr = 0;      wi = -32767; end
      default: begin wr = -23170; wi = -23170; end
    endcase
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    pr = (br * wr - bi * wi) >>> 15;
    pi = (br * wi + bi * wr) >>> 15;
    yr = lower ? ar - pr : ar + pr;
    yi = lower ? ai - pi : ai + pi;
    return {16'(yr), 16'(yi)};
  endfunction

  // Butterfly unit model
  int bf_delay = 0;
  int bf_wait = 0;
  assign bf_ready = (bf_delay == 0) ? 1'b1 : (bf_valid && (bf_wait >= bf_delay));
  assign bf_ya = bfly_ref(bf_a, bf_b, bf_tw, 1'b0);
  assign bf_yb = bfly_ref(bf_a, bf_b, bf_tw, 1'b1);
  always @(posedge clk) begin
    if (bf_valid && !bf_ready) bf_wait <= bf_wait + 1;
    else bf_wait <= 0;
  end

  // Data memory model: combinational read, bulk image load for setup.
  logic [31:0] mem [32];
  logic [31:0] init_img [32];
  logic        load_req = 1'b0;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_img[i];
    end else if (dm_sel && mem_wena) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Scoreboard
  logic [4:0]  rd_q [$];
  logic [36:0] wr_q [$];
  logic [65:0] op_q [$];
  logic [31:0] exp_out [8];
  logic [4:0]  rd_log [$];
  logic [1:0]  tw_log [$];
  logic [4:0]  run_base = '0;
  int rd_cnt, wr_cnt, stall_bad, range_bad, unstable;
  bit holding = 1'b0;
  logic [31:0] hold_a, hold_b;
  logic [1:0]  hold_tw;

  logic [4:0] pair_tab [24] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                5'd0, 5'd2, 5'd1, 5'd3, 5'd4, 5'd6, 5'd5, 5'd7,
                                5'd0, 5'd4, 5'd1, 5'd5, 5'd2, 5'd6, 5'd3, 5'd7};

  always @(negedge clk) begin
    if (rst) begin
      if (busy && !stall) stall_bad++;
      if ((mem_rena || mem_wena) && (5'(mem_addr - run_base) >= 5'd8)) range_bad++;
      if (mem_rena) begin
        rd_cnt++;
        rd_log.push_back(mem_addr);
        if (rd_q.size() == 0) chk("rd_unexpected", rd_q.size(), 1);
        else chk("rd_addr", mem_addr, rd_q.pop_front());
      end
      if (mem_wena) begin
        logic [36:0] w;
        wr_cnt++;
        if (wr_q.size() == 0) chk("wr_unexpected", wr_q.size(), 1);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", mem_addr, w[36:32]);
          chk("wr_data", mem_wdata, w[31:0]);
        end
      end
      if (bf_valid) begin
        if (holding) begin
          if (bf_a !== hold_a || bf_b !== hold_b || bf_tw !== hold_tw) unstable++;
        end else begin
          hold_a = bf_a;
          hold_b = bf_b;
          hold_tw = bf_tw;
          holding = 1'b1;
        end
        if (bf_ready) begin
          logic [65:0] o;
          holding = 1'b0;
          tw_log.push_back(bf_tw);
          if (op_q.size() == 0) chk("op_unexpected", op_q.size(), 1);
          else begin
            o = op_q.pop_front();
            chk("bf_a", bf_a, o[65:34]);
            chk("bf_b", bf_b, o[33:2]);
            chk("bf_tw", 32'(bf_tw), 32'(o[1:0]));
          end
        end
      end
    end
  end

  // Reference schedule: stage by stage, group-major then position within group.
  task automatic build_ref(input logic [4:0] base);
    logic [31:0] m [8];
    logic [31:0] a, b, ya, yb;
    int half, ia, ib, tw;
    for (int i = 0; i < 8; i++) m[i] = init_img[5'(base + 5'(i))];
    for (int s = 0; s < 3; s++) begin
      half = 1 << s;
      for (int g = 0; g < 4 / half; g++) begin
        for (int p = 0; p < half; p++) begin
          ia = g * 2 * half + p;
          ib = ia + half;
          tw = p * (4 / half);
          a = m[ia];
          b = m[ib];
          ya = bfly_ref(a, b, 2'(tw), 1'b0);
          yb = bfly_ref(a, b, 2'(tw), 1'b1);
          rd_q.push_back(5'(base + 5'(ia)));
          rd_q.push_back(5'(base + 5'(ib)));
          op_q.push_back({a, b, 2'(tw)});
          wr_q.push_back({5'(base + 5'(ia)), ya});
          wr_q.push_back({5'(base + 5'(ib)), yb});
          m[ia] = ya;
          m[ib] = yb;
        end
      end
    end
    for (int i = 0; i < 8; i++) exp_out[i] = m[i];
  endtask

  task automatic load_image();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_dm_sel"}, 32'(dm_sel), 0);
    chk({tag, "_rena"}, 32'(mem_rena), 0);
    chk({tag, "_wena"}, 32'(mem_wena), 0);
    chk({tag, "_bf_valid"}, 32'(bf_valid), 0);
    chk({tag, "_bf_a"}, bf_a, 0);
  endtask

  task automatic prep_run(input logic [4:0] base, input int delay);
    bf_delay = delay;
    rd_cnt = 0;
    wr_cnt = 0;
    stall_bad = 0;
    range_bad = 0;
    unstable = 0;
    run_base = base;
    rd_log.delete();
    tw_log.delete();
    build_ref(base);
  endtask

  task automatic do_run(input logic [4:0] base, input int delay, input int exp_lat,
                        input bit poke);
    int cnt;
    int busy_gap;
    bit got;
    prep_run(base, delay);
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    #1;
    chk("stall_on_start", 32'(stall), 1);
    cnt = 0;
    got = 1'b0;
    busy_gap = 0;
    while (cnt < 2000 && !got) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) start = 1'b0;
      if (poke && cnt == 10) begin
        start = 1'b1;
        base_addr = 5'd17;
      end
      if (poke && cnt == 11) begin
        start = 1'b0;
        base_addr = base;
      end
      if (done) got = 1'b1;
      else if (!busy || !stall) busy_gap++;
    end
    chk("latency", 32'(cnt), 32'(exp_lat));
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 0);
    chk("dm_sel_after_done", 32'(dm_sel), 0);
    chk("read_count", 32'(rd_cnt), 24);
    chk("write_count", 32'(wr_cnt), 24);
    chk("busy_stall_gap", 32'(busy_gap), 0);
    chk("stall_vs_busy", 32'(stall_bad), 0);
    chk("operand_unstable", 32'(unstable), 0);
    chk("addr_out_of_window", 32'(range_bad), 0);
    chk("rd_q_left", 32'(rd_q.size()), 0);
    chk("wr_q_left", 32'(wr_q.size()), 0);
    chk("op_q_left", 32'(op_q.size()), 0);
    for (int i = 0; i < 8; i++) chk("mem_result", mem[5'(base + 5'(i))], exp_out[i]);
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < 32; i++) init_img[i] = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_mem_addr", 32'(mem_addr), 0);
    chk("reset_stall", 32'(stall), 0);
    rst = 1'b1;

    // Impulse at base 0, ready tied high, a stray start mid-run
    init_img[0] = 32'h7FFF_0000;
    load_image();
    do_run(5'd0, 0, 73, 1'b1);
    for (int i = 0; i < 24; i++) begin
      if (i < rd_log.size()) chk("stage_pair_addr", rd_log[i], pair_tab[i]);
      else chk("stage_pair_missing", 32'(rd_log.size()), 24);
    end
    for (int i = 0; i < 4; i++) begin
      if (8 + i < tw_log.size()) chk("stage2_tw", 32'(tw_log[8 + i]), 32'(i));
      else chk("stage2_tw_missing", 32'(tw_log.size()), 12);
    end
    for (int i = 0; i < 8; i++) chk("impulse_out", mem[i], 32'h7FFF_0000);

    // Random data at base 30 (wraps), butterfly ready delayed 3 cycles
    for (int i = 0; i < 32; i++) init_img[i] = $urandom;
    load_image();
    do_run(5'd30, 3, 109, 1'b0);

    // Reset in the middle of a run, then a full run afterwards
    for (int i = 0; i < 32; i++) init_img[i] = $urandom;
    load_image();
    prep_run(5'd5, 0);
    @(negedge clk);
    start = 1'b1;
    base_addr = 5'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("busy_before_abort", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check_idle_outputs("abort");
    rd_q.delete();
    wr_q.delete();
    op_q.delete();
    holding = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    load_image();
    do_run(5'd5, 0, 73, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fft_seq.md
FFT_SEQ -- requirements
Module: fft_seq

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low, with ports named clk and rst.
REQ-002 clk  in  1  core clock, shared with the pipeline registers.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 start  in  1  one-cycle request from EX stage (FFT custom op) to begin an 8-point FFT.
REQ-005 base_addr  in  5  data-memory word address of x[0]; input is stored bit-reversed, complex packed {re[31:16], im[15:0]}.
REQ-006 busy  out  1  high from accepted start until done.
REQ-007 done  out  1  one-cycle pulse after the last write.
REQ-008 stall  out  1  holds PC, IF/ID and ID/EX (same sense as the hazard "continue" signals being deasserted); equals busy | start.
REQ-009 dm_sel  out  1  1 = data-memory port owned by fft_seq, 0 = owned by the EX/MEM register.
REQ-010 mem_rena / mem_wena  out  1 each  data-memory strobes when dm_sel=1.
REQ-011 mem_addr  out  5  data-memory word address.
REQ-012 mem_wdata  out  32  write data.
REQ-013 mem_rdata  in  32  combinational read data (same-cycle).
REQ-014 bf_a, bf_b  out  32 each  butterfly operands; bf_tw  out  2  twiddle index W8^k.
REQ-015 bf_valid  out  1 / bf_ready  in  1  butterfly handshake; bf_ya, bf_yb  in  32 each  results, valid while bf_ready=1.

Function
REQ-016 States: IDLE, RD_A, RD_B, CALC, WR_A, WR_B, NEXT, FIN.
REQ-017 IDLE: start=1 latches base_addr, clears stage s=0 and butterfly k=0, goes to RD_A; start while busy SHALL be ignored.
REQ-018 Per butterfly: half=1<<s, pos=k&(half-1), grp=k>>s, ia=grp*2*half+pos, ib=ia+half, tw=pos<<(2-s).
REQ-019 mem_addr=(base+ia) mod 32 in RD_A/WR_A and (base+ib) mod 32 in RD_B/WR_B; wrap-around is silent.
REQ-020 RD_A/RD_B assert mem_rena for one cycle and capture mem_rdata into operand registers at the clock edge.
REQ-021 CALC holds bf_valid=1 with bf_a, bf_b, bf_tw stable until bf_ready=1, then latches bf_ya/bf_yb and goes to WR_A; there is no timeout.
REQ-022 WR_A writes ya, WR_B writes yb, one cycle each with mem_wena=1.
REQ-023 NEXT: if k<3, k++ and go to RD_A; else if s<2, s++, k=0 and go to RD_A; else go to FIN.
REQ-024 FIN asserts done for one cycle, returns to IDLE, and drops busy in the same cycle.
REQ-025 Nominal latency: start to done = 12 butterflies × (6 + CALC wait) + 1 cycles; with bf_ready already high, 73 cycles.
REQ-026 dm_sel=1 in every state except IDLE; mem_rena=mem_wena=0 in CALC, NEXT, FIN and IDLE.
REQ-027 The pipeline SHALL issue no memory access while stall=1, so no arbitration conflict exists; a start coincident with an EX/MEM access lets that access complete in the same cycle, because dm_sel rises one cycle later.

Reset
REQ-028 rst low SHALL force IDLE with s=k=0 and busy=done=dm_sel=mem_rena=mem_wena=bf_valid=0, and all data and address registers =0.
REQ-029 Reset mid-operation SHALL abort immediately; partial memory results are left as written.

Structure
REQ-030 The shared package SHALL hold the state encoding, FFT_N=8, FFT_STAGES=3, and DM_AW=5.
REQ-031 Address generation (REQ-018/019) SHALL be one combinational sub-module, fft_addr_gen.

Verification
REQ-032 Reset then start with base_addr=0 and bf_ready tied 1 -> done exactly 73 cycles later; stall high throughout; 24 reads and 24 writes.
REQ-033 Stage-address check with base=0 -> butterfly pairs (0,1)(2,3)(4,5)(6,7), (0,2)(1,3)(4,6)(5,7), (0,4)(1,5)(2,6)(3,7); tw for stage 2 = 0,1,2,3.
REQ-034 base_addr=30 -> addresses wrap to 30,31,0..5; no out-of-range address.
REQ-035 bf_ready delayed 3 cycles per butterfly -> bf_a/bf_b/bf_tw stable during the wait; done at cycle 109.
REQ-036 Impulse x[0]=0x7FFF0000, other words 0, with a reference butterfly model -> all 8 outputs equal 0x7FFF0000 (unscaled model).
REQ-037 rst low at cycle 20 of a run -> outputs at reset values next edge; a new start after rst release runs the full 73 cycles.
